// File: rtl/pipe_stage_register.sv
// Generic pipeline stage register: valid/ready handshake, two-entry skid,
// flush, and a saturating bubble counter. Bubbles drive a no-op control word.
`timescale 1ns/1ps
module pipe_stage_register #(
    parameter int unsigned DATA_W              = 96,
    parameter int unsigned CTRL_W              = 8,
    parameter int unsigned ADDR_W              = 5,
    parameter int unsigned NUM_ADDR            = 3,
    parameter logic [CTRL_W-1:0] NOOP_CTRL     = 8'h01,
    parameter int unsigned CNT_W               = 16
) (
    input  logic                       clk,
    input  logic                       rst_b,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic [NUM_ADDR*ADDR_W-1:0] in_addr,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [NUM_ADDR*ADDR_W-1:0] out_addr,
    output logic [CNT_W-1:0]           bubble_count
);

    localparam int unsigned AW = NUM_ADDR * ADDR_W;

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
    logic [AW-1:0]     main_addr_q,  main_addr_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic [AW-1:0]     skid_addr_q,  skid_addr_d;
    logic [CNT_W-1:0]  bubble_q,     bubble_d;
    logic              accept;

    assign in_ready     = !skid_valid_q;
    assign accept       = in_valid && in_ready;
    assign out_valid    = main_valid_q;
    assign out_data     = main_data_q;
    assign out_ctrl     = main_valid_q ? main_ctrl_q : NOOP_CTRL;
    assign out_addr     = main_valid_q ? main_addr_q : '0;
    assign bubble_count = bubble_q;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_ctrl_d  = main_ctrl_q;
        main_addr_d  = main_addr_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_addr_d  = skid_addr_q;
        bubble_d     = bubble_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_valid_q && !out_ready) begin
            if (accept) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
                skid_ctrl_d  = in_ctrl;
                skid_addr_d  = in_addr;
            end
        end else if (skid_valid_q) begin
            // in_ready is low here, so no accept can collide with the move
            main_valid_d = 1'b1;
            main_data_d  = skid_data_q;
            main_ctrl_d  = skid_ctrl_q;
            main_addr_d  = skid_addr_q;
            skid_valid_d = 1'b0;
        end else begin
            main_valid_d = accept;
            if (accept) begin
                main_data_d = in_data;
                main_ctrl_d = in_ctrl;
                main_addr_d = in_addr;
            end
        end

        if (out_ready && !main_valid_q && (bubble_q != '1)) begin
            bubble_d = bubble_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_ctrl_q  <= NOOP_CTRL;
            main_addr_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= NOOP_CTRL;
            skid_addr_q  <= '0;
            bubble_q     <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_ctrl_q  <= main_ctrl_d;
            main_addr_q  <= main_addr_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_addr_q  <= skid_addr_d;
            bubble_q     <= bubble_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_register.sv
// Directed bench for pipe_stage_register: reset, streaming, backpressure,
// flush, bubble saturation and asynchronous reset while full.
`timescale 1ns/1ps
module tb_pipe_stage_register;

    logic         clk = 1'b0;
    logic         rst_b;
    logic         in_valid;
    logic         in_ready;
    logic [95:0]  in_data;
    logic [7:0]   in_ctrl;
    logic [14:0]  in_addr;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [95:0]  out_data;
    logic [7:0]   out_ctrl;
    logic [14:0]  out_addr;
    logic [15:0]  bubble_count;

    logic         s_in_ready;
    logic         s_out_valid;
    logic [95:0]  s_out_data;
    logic [7:0]   s_out_ctrl;
    logic [14:0]  s_out_addr;
    logic [3:0]   s_bubble;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pipe_stage_register dut (
        .clk(clk), .rst_b(rst_b),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_addr(in_addr),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_addr(out_addr),
        .bubble_count(bubble_count)
    );

    pipe_stage_register #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_b(rst_b),
        .in_valid(1'b0), .in_ready(s_in_ready),
        .in_data(96'd0), .in_ctrl(8'd0), .in_addr(15'd0),
        .flush(1'b0),
        .out_valid(s_out_valid), .out_ready(1'b1),
        .out_data(s_out_data), .out_ctrl(s_out_ctrl), .out_addr(s_out_addr),
        .bubble_count(s_bubble)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [95:0] d, input logic [7:0] c,
                        input logic [14:0] a);
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = c;
        in_addr  = a;
    endtask

    initial begin
        rst_b     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        in_addr   = '0;
        flush     = 1'b0;
        out_ready = 1'b1;

        // reset values
        #3;
        chk("rst_out_ctrl", 128'(out_ctrl), 128'h01);
        chk("rst_out_addr", 128'(out_addr), 128'h0);
        chk("rst_out_valid", 128'(out_valid), 128'h0);
        chk("rst_in_ready", 128'(in_ready), 128'h1);
        chk("rst_out_data", 128'(out_data), 128'h0);
        chk("rst_bubble", 128'(bubble_count), 128'h0);
        #9 rst_b = 1'b1;

        repeat (4) tick();
        chk("bubble_4", 128'(bubble_count), 128'd4);
        chk("sat_bubble_4", 128'(s_bubble), 128'd4);
        repeat (11) tick();
        chk("sat_bubble_15", 128'(s_bubble), 128'd15);
        repeat (5) tick();
        chk("sat_bubble_hold", 128'(s_bubble), 128'd15);
        chk("bubble_20", 128'(bubble_count), 128'd20);

        // streaming 1..8
        for (int i = 1; i <= 8; i++) begin
            beat(96'(i), 8'(8'h10 + i), 15'(i));
            tick();
            chk($sformatf("stream_valid_%0d", i), 128'(out_valid), 128'h1);
            chk($sformatf("stream_data_%0d", i), 128'(out_data), 128'(i));
            chk($sformatf("stream_ctrl_%0d", i), 128'(out_ctrl),
                128'(8'h10 + i));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_end_valid", 128'(out_valid), 128'h0);
        chk("stream_end_ctrl", 128'(out_ctrl), 128'h01);
        chk("stream_end_addr", 128'(out_addr), 128'h0);
        chk("bubble_21", 128'(bubble_count), 128'd21);

        // backpressure
        beat(96'hA, 8'h2A, 15'h1234);
        tick();
        chk("bp_a_valid", 128'(out_valid), 128'h1);
        chk("bp_a_data", 128'(out_data), 128'hA);
        out_ready = 1'b0;
        beat(96'hB, 8'h2B, 15'h0567);
        tick();
        in_valid = 1'b0;
        chk("bp_skid_in_ready", 128'(in_ready), 128'h0);
        chk("bp_hold_data", 128'(out_data), 128'hA);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("bp_stall_data_%0d", i), 128'(out_data), 128'hA);
            chk($sformatf("bp_stall_rdy_%0d", i), 128'(in_ready), 128'h0);
        end
        chk("bp_a_addr", 128'(out_addr), 128'h1234);
        out_ready = 1'b1;
        tick();
        chk("bp_b_valid", 128'(out_valid), 128'h1);
        chk("bp_b_data", 128'(out_data), 128'hB);
        chk("bp_b_ctrl", 128'(out_ctrl), 128'h2B);
        chk("bp_b_in_ready", 128'(in_ready), 128'h1);
        tick();
        chk("bp_empty_valid", 128'(out_valid), 128'h0);

        // flush with the stage full
        out_ready = 1'b0;
        beat(96'h100, 8'h3A, 15'h0011);
        tick();
        beat(96'h200, 8'h3B, 15'h0022);
        tick();
        chk("fl_full_in_ready", 128'(in_ready), 128'h0);
        beat(96'h300, 8'h3C, 15'h0033);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", 128'(out_valid), 128'h0);
        chk("fl_ctrl", 128'(out_ctrl), 128'h01);
        chk("fl_addr", 128'(out_addr), 128'h0);
        chk("fl_in_ready", 128'(in_ready), 128'h1);
        out_ready = 1'b1;
        tick();
        chk("fl_nothing_after", 128'(out_valid), 128'h0);

        // flush with an accept into an empty stage
        beat(96'h400, 8'h3D, 15'h0044);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_acc_valid", 128'(out_valid), 128'h0);
        chk("fl_acc_in_ready", 128'(in_ready), 128'h1);

        // asynchronous reset while full
        out_ready = 1'b0;
        beat(96'h500, 8'h4A, 15'h0055);
        tick();
        beat(96'h600, 8'h4B, 15'h0066);
        tick();
        in_valid = 1'b0;
        chk("ar_full_valid", 128'(out_valid), 128'h1);
        chk("ar_full_in_ready", 128'(in_ready), 128'h0);
        #2 rst_b = 1'b0;
        #1;
        chk("ar_valid", 128'(out_valid), 128'h0);
        chk("ar_in_ready", 128'(in_ready), 128'h1);
        chk("ar_ctrl", 128'(out_ctrl), 128'h01);
        chk("ar_addr", 128'(out_addr), 128'h0);
        chk("ar_data", 128'(out_data), 128'h0);
        chk("ar_bubble", 128'(bubble_count), 128'h0);
        tick();
        rst_b     = 1'b1;
        out_ready = 1'b1;
        beat(96'h700, 8'h4C, 15'h0077);
        tick();
        in_valid = 1'b0;
        chk("ar_first_valid", 128'(out_valid), 128'h1);
        chk("ar_first_data", 128'(out_data), 128'h700);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipe_stage_register.md
# pipe_stage_register

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer, flush, and a bubble counter. It is the generic successor to the fixed decode/execute latch and sits between any two pipeline stages (decode/execute, execute/memory, memory/writeback). When the output is invalid, it presents a no-op control word and zeroed register addresses, so downstream hazard and forwarding logic never matches a bubble.

## Interface

Parameters:
- DATA_W, 96: payload width (operands, immediate, PC), passed through untouched.
- CTRL_W, 8: control word width (alu_op, mem/reg enables, branch, ...).
- ADDR_W, 5: width of one register address field.
- NUM_ADDR, 3: number of register address fields (rs/rt/rd).
- NOOP_CTRL, 8'h01: control value driven when the output is invalid and at reset.
- CNT_W, 16: bubble counter width.

Ports:
- clk, input, 1: rising-edge clock.
- rst_b, input, 1: reset. One clock; asynchronous, active-low.
- in_valid, input, 1: upstream beat present.
- in_ready, output, 1: stage can accept a beat; equals NOT skid_valid (registered state only).
- in_data, input, DATA_W: upstream payload.
- in_ctrl, input, CTRL_W: upstream control word.
- in_addr, input, NUM_ADDR*ADDR_W: packed register addresses; field i is bits [i*ADDR_W +: ADDR_W].
- flush, input, 1: synchronous kill of all held and incoming beats.
- out_valid, output, 1: main entry holds a beat.
- out_ready, input, 1: downstream accepts a beat.
- out_data, output, DATA_W: main entry payload.
- out_ctrl, output, CTRL_W: main entry control when out_valid=1, else NOOP_CTRL.
- out_addr, output, NUM_ADDR*ADDR_W: main entry addresses when out_valid=1, else 0.
- bubble_count, output, CNT_W: saturating count of bubbles issued downstream.

## Operation

- Storage: main entry (valid, data, ctrl, addr) drives the outputs. Skid entry (valid, data, ctrl, addr) catches one beat accepted while the main entry is stalled.
- Accept: in_valid && in_ready. Drain: out_valid && out_ready.
- Main empty, or main draining with skid empty: an accepted beat loads main.
- Main stalled (out_valid && !out_ready) with a beat accepted: the beat loads skid.
- Main draining with skid full: skid moves to main and skid clears. in_ready is 0 that cycle, so no accept can occur.
- Order is strictly FIFO. A beat is never duplicated or dropped, except by flush.
- Flush has priority over everything. At the edge, main.valid and skid.valid clear, and any beat accepted that cycle is discarded. The data and address registers of cleared entries are not required to change. The outputs still show NOOP_CTRL and zero addresses through the out_valid gating.
- bubble_count increments at each edge where out_ready=1 and out_valid=0. It saturates at all-ones and does not wrap. Flush does not reset it.
- Output gating: out_ctrl and out_addr are a mux on main.valid. out_data is ungated.

## Timing

- Reset (rst_b low, asynchronous): out_valid=0, skid.valid=0, in_ready=1, out_ctrl=NOOP_CTRL, out_addr=0, out_data=0, bubble_count=0.
- Upstream must hold in_valid=0 while rst_b is low.
- Reset may assert at any cycle. In-flight beats are lost and the state equals the post-reset state. The first accept is possible at the first rising edge after rst_b rises.
- Latency: 1 cycle from accept to out_valid when the stage is empty.
- Throughput: 1 beat/cycle when out_ready is held at 1.
- in_ready falls the cycle after a skid load. It rises the cycle after the skid moves to main, or the cycle after a flush.
- Sustained stall: the stage holds at most 2 beats. Upstream sees in_ready=0 from the cycle after the second beat is accepted.
- Flush together with an accept: the beat is dropped, and out_valid=0 and in_ready=1 on the next cycle.
- Flush together with a drain: the drained beat counts as consumed by downstream, and the stage is empty next cycle.

## Test plan

- Reset check: during reset, out_ctrl=8'h01, out_addr=0, out_valid=0, in_ready=1. After release with idle input and out_ready=1 for 4 cycles, bubble_count=4.
- Streaming: send beats with data 1..8 and in_valid and out_ready held at 1. Outputs 1..8 appear in order with 1-cycle latency and no gaps.
- Backpressure: send A and B, and drop out_ready at the edge where A appears.
  - B is stored in skid and in_ready falls next cycle.
  - Raise out_ready after 3 cycles: A then B emerge on consecutive cycles, then in_ready returns to 1. No loss and no duplicates.
- Flush: with the stage full (main=A, skid=B), assert flush together with in_valid carrying C.
  - Next cycle: out_valid=0, out_ctrl=NOOP_CTRL, out_addr=0, in_ready=1.
  - A, B and C never appear.
- Saturation: with CNT_W=4 and idle input for 20 cycles, bubble_count stops at 15.
- Asynchronous reset mid-stall: with the stage full, pulse rst_b low between clock edges. Outputs go to reset values immediately, without waiting for a clock edge.
